// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encodings and saturation helpers for alu_pipe.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_NOR = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;
  localparam logic [3:0] ALU_LHB = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Signed range limits for a w-bit datapath; callers truncate to w bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add magnitude multiplier: bit 0 handled on start, one bit per cycle after.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      cnt    <= CW'(WIDTH - 1);
    end else if (cnt != '0) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  // Counter parks at zero, so the product stays put until the next start.
  assign done = (cnt == '0);

endmodule

// File: rtl/alu_pipe.sv
// Handshaked EX-stage ALU with registered result/flags.
// Define ALU_MUL_EN to add the iterative signed saturating multiply (opcode 8).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [SHW-1:0]   shAmt,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] dst,
  output logic             ov,
  output logic             zr,
  output logic             neg
);

  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  logic             accept;
  logic             wr_en;
  logic [WIDTH-1:0] res_d;
  logic             res_ov;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_d;
  logic             alu_ov;

  assign accept = in_vld & in_rdy;

  // Sign-extended so the top two bits disagree exactly on signed overflow.
  assign sum  = {src0[WIDTH-1], src0} + {src1[WIDTH-1], src1};
  assign diff = {src0[WIDTH-1], src0} - {src1[WIDTH-1], src1};

  always_comb begin
    alu_d  = '0;
    alu_ov = 1'b0;
    case (aluOp)
      ALU_ADD: begin
        alu_ov = sum[WIDTH] ^ sum[WIDTH-1];
        alu_d  = alu_ov ? (sum[WIDTH] ? SMIN : SMAX) : sum[WIDTH-1:0];
      end
      ALU_SUB: begin
        alu_ov = diff[WIDTH] ^ diff[WIDTH-1];
        alu_d  = alu_ov ? (diff[WIDTH] ? SMIN : SMAX) : diff[WIDTH-1:0];
      end
      ALU_AND: alu_d = src0 & src1;
      ALU_NOR: alu_d = ~(src0 | src1);
      ALU_SLL: alu_d = src0 << shAmt;
      ALU_SRL: alu_d = src0 >> shAmt;
      ALU_SRA: alu_d = $signed(src0) >>> shAmt;
      ALU_LHB: alu_d = {src1[WIDTH/2-1:0], src0[WIDTH/2-1:0]};
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [1:0]         state;
  logic               mul_start;
  logic               mul_done;
  logic               mul_fin;
  logic               mul_neg;
  logic               mul_ov;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   mul_d;
  logic [2*WIDTH-1:0] prod;

  assign mul_start = accept & (aluOp == ALU_MUL);
  assign a_mag     = src0[WIDTH-1] ? -src0 : src0;
  assign b_mag     = src1[WIDTH-1] ? -src1 : src1;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a_mag),
    .b     (b_mag),
    .prod  (prod),
    .done  (mul_done)
  );

  // A negative result may reach magnitude 2^(WIDTH-1); a positive one may not.
  always_comb begin
    mul_ov = 1'b0;
    mul_d  = prod[WIDTH-1:0];
    if (mul_neg) begin
      if (prod > {{WIDTH{1'b0}}, SMIN}) begin
        mul_ov = 1'b1;
        mul_d  = SMIN;
      end else begin
        mul_d  = -prod[WIDTH-1:0];
      end
    end else if (prod > {{WIDTH{1'b0}}, SMAX}) begin
      mul_ov = 1'b1;
      mul_d  = SMAX;
    end
  end

  // Completion waits until the output register is free.
  assign mul_fin = ((state == ST_MUL && mul_done) || state == ST_HOLD) && (!out_vld || out_rdy);
  assign in_rdy  = (state == ST_IDLE) && (!out_vld || out_rdy);
  assign wr_en   = (accept && aluOp != ALU_MUL) || mul_fin;
  assign res_d   = mul_fin ? mul_d  : alu_d;
  assign res_ov  = mul_fin ? mul_ov : alu_ov;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mul_neg <= 1'b0;
    end else begin
      if (mul_start) mul_neg <= src0[WIDTH-1] ^ src1[WIDTH-1];
      case (state)
        ST_IDLE: if (mul_start) state <= ST_MUL;
        ST_MUL:  if (mul_done) state <= mul_fin ? ST_IDLE : ST_HOLD;
        ST_HOLD: if (mul_fin) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_rdy = !out_vld || out_rdy;
  assign wr_en  = accept;
  assign res_d  = alu_d;
  assign res_ov = alu_ov;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      dst     <= '0;
      ov      <= 1'b0;
      zr      <= 1'b1;
      neg     <= 1'b0;
    end else if (wr_en) begin
      out_vld <= 1'b1;
      dst     <= res_d;
      ov      <= res_ov;
      zr      <= (res_d == '0);
      neg     <= res_d[WIDTH-1];
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=16); MUL section follows ALU_MUL_EN.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [3:0]  aluOp;
  logic [15:0] src0;
  logic [15:0] src1;
  logic [3:0]  shAmt;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] dst;
  logic        ov;
  logic        zr;
  logic        neg;

  int npass = 0;
  int ntot  = 0;

  alu_pipe #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .aluOp   (aluOp),
    .src0    (src0),
    .src1    (src1),
    .shAmt   (shAmt),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .dst     (dst),
    .ov      (ov),
    .zr      (zr),
    .neg     (neg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // flags packed as {out_vld, ov, zr, neg}
  task automatic chk_res(input string tag, input logic [15:0] exp_d, input logic [3:0] exp_f);
    chk({tag, ".dst"}, {16'h0, dst}, {16'h0, exp_d});
    chk({tag, ".flags"}, {28'h0, out_vld, ov, zr, neg}, {28'h0, exp_f});
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    in_vld = 1'b1;
    aluOp  = op;
    src0   = a;
    src1   = b;
    shAmt  = sh;
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; aluOp = 4'd0; src0 = '0; src1 = '0; shAmt = '0; out_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_res("reset", 16'h0000, 4'b0010);
    chk("reset.in_rdy", {31'h0, in_rdy}, 32'h1);

    drive(4'd0, 16'h7FFF, 16'h0001, 4'd0); tick();
    chk_res("add_pos_sat", 16'h7FFF, 4'b1100);
    drive(4'd1, 16'h8000, 16'h0001, 4'd0); tick();
    chk_res("sub_neg_sat", 16'h8000, 4'b1101);
    drive(4'd1, 16'h0005, 16'h0005, 4'd0); tick();
    chk_res("sub_zero", 16'h0000, 4'b1010);
    drive(4'd6, 16'h8000, 16'h0000, 4'd15); tick();
    chk_res("sra15", 16'hFFFF, 4'b1001);
    chk("b2b.in_rdy", {31'h0, in_rdy}, 32'h1);
    drive(4'd7, 16'h12AB, 16'h34CD, 4'd0); tick();
    chk_res("lhb", 16'hCDAB, 4'b1001);
    drive(4'd2, 16'hF0F0, 16'h3C3C, 4'd0); tick();
    chk_res("and", 16'h3030, 4'b1000);
    drive(4'd3, 16'hF0F0, 16'h0F00, 4'd0); tick();
    chk_res("nor", 16'h000F, 4'b1000);
    drive(4'd4, 16'h0001, 16'h0000, 4'd4); tick();
    chk_res("sll4", 16'h0010, 4'b1000);
    drive(4'd5, 16'h8000, 16'h0000, 4'd15); tick();
    chk_res("srl15", 16'h0001, 4'b1000);
    drive(4'd0, 16'h8000, 16'hFFFF, 4'd0); tick();
    chk_res("add_neg_sat", 16'h8000, 4'b1101);
    drive(4'd9, 16'h1234, 16'h5678, 4'd0); tick();
    chk_res("illegal9", 16'h0000, 4'b1010);

    // backpressure: result must hold while out_rdy is low
    in_vld = 1'b0; tick();
    chk("drain.out_vld", {31'h0, out_vld}, 32'h0);
    drive(4'd0, 16'h0002, 16'h0003, 4'd0); out_rdy = 1'b0; tick();
    chk_res("bp_first", 16'h0005, 4'b1000);
    drive(4'd0, 16'h0010, 16'h0020, 4'd0);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_rdy", {31'h0, in_rdy}, 32'h0);
      chk_res("bp_hold", 16'h0005, 4'b1000);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_release.in_rdy", {31'h0, in_rdy}, 32'h1);
    tick();
    chk_res("bp_next", 16'h0030, 4'b1000);
    in_vld = 1'b0; tick();
    chk("bp_drain.out_vld", {31'h0, out_vld}, 32'h0);

`ifdef ALU_MUL_EN
    drive(4'd8, 16'hFFFD, 16'h0005, 4'd0); tick();
    in_vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("mul_busy.out_vld", {31'h0, out_vld}, 32'h0);
      chk("mul_busy.in_rdy", {31'h0, in_rdy}, 32'h0);
      tick();
    end
    chk_res("mul_m3x5", 16'hFFF1, 4'b1001);

    drive(4'd8, 16'h0100, 16'h0100, 4'd0); tick();
    in_vld = 1'b0;
    repeat (16) tick();
    chk_res("mul_sat", 16'h7FFF, 4'b1100);

    drive(4'd8, 16'h8000, 16'h0001, 4'd0); tick();
    in_vld = 1'b0;
    repeat (16) tick();
    chk_res("mul_min", 16'h8000, 4'b1001);

    drive(4'd8, 16'h0002, 16'h0003, 4'd0); tick();
    in_vld = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk_res("mul_rst", 16'h0000, 4'b0010);
    rst = 1'b0;
    repeat (20) tick();
    chk("mul_rst_after.out_vld", {31'h0, out_vld}, 32'h0);
    chk("mul_rst_after.in_rdy", {31'h0, in_rdy}, 32'h1);
    drive(4'd0, 16'h0001, 16'h0001, 4'd0); tick();
    chk_res("post_rst_add", 16'h0002, 4'b1000);
    in_vld = 1'b0;
`else
    drive(4'd8, 16'h0005, 16'h0005, 4'd0);
    #1;
    chk("op8.in_rdy_pre", {31'h0, in_rdy}, 32'h1);
    tick();
    chk_res("op8_illegal", 16'h0000, 4'b1010);
    chk("op8.in_rdy_post", {31'h0, in_rdy}, 32'h1);
    drive(4'd0, 16'h0001, 16'h0001, 4'd0); tick();
    chk_res("op8_next", 16'h0002, 4'b1000);
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk_res("rst_pulse", 16'h0000, 4'b0010);
    rst = 1'b0;
    tick();
    chk("rst_pulse.in_rdy", {31'h0, in_rdy}, 32'h1);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
